seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seg_pkg.sv | 21 ++
 rtl/bcd_to_seg.sv | 27 ++
 rtl/seven_seg_scanner.sv | 145 ++++++++++++++
 tb/tb_seven_seg_scanner.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment glyphs (active-high, bit 0 = segment a) and the special
// digit codes used by the scanner.
package seg_pkg;

  localparam logic [3:0] DASH  = 4'hA;
  localparam logic [3:0] BLANK = 4'hF;

  localparam logic [6:0] GLYPH_0    = 7'h3F;
  localparam logic [6:0] GLYPH_1    = 7'h06;
  localparam logic [6:0] GLYPH_2    = 7'h5B;
  localparam logic [6:0] GLYPH_3    = 7'h4F;
  localparam logic [6:0] GLYPH_4    = 7'h66;
  localparam logic [6:0] GLYPH_5    = 7'h6D;
  localparam logic [6:0] GLYPH_6    = 7'h7D;
  localparam logic [6:0] GLYPH_7    = 7'h07;
  localparam logic [6:0] GLYPH_8    = 7'h7F;
  localparam logic [6:0] GLYPH_9    = 7'h6F;
  localparam logic [6:0] GLYPH_DASH = 7'h40;
  localparam logic [6:0] GLYPH_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg.sv
// Nibble to active-high 7-segment glyph; 10 is a dash, 11-15 are blank.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_OFF;
    case (bcd)
      4'd0:    seg = GLYPH_0;
      4'd1:    seg = GLYPH_1;
      4'd2:    seg = GLYPH_2;
      4'd3:    seg = GLYPH_3;
      4'd4:    seg = GLYPH_4;
      4'd5:    seg = GLYPH_5;
      4'd6:    seg = GLYPH_6;
      4'd7:    seg = GLYPH_7;
      4'd8:    seg = GLYPH_8;
      4'd9:    seg = GLYPH_9;
      DASH:    seg = GLYPH_DASH;
      default: seg = GLYPH_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed two-page 7-segment scanner: slot divider, digit index, debounced
// page switch applied at frame boundaries, and per-frame digit snapshot.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned CLK_DIV        = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    page_sel,
  input  logic [4*NUM_DIGITS-1:0] page0_bcd,
  input  logic [4*NUM_DIGITS-1:0] page1_bcd,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    page_active
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned BCD_W = 4 * NUM_DIGITS;

  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [6:0]            SEG_XOR  = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_XOR   = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [DIV_W-1:0]      div_q;
  logic                  tick;
  logic                  frame_end;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_next;

  logic [1:0]            sync_q;
  logic                  sel_sync;
  logic                  sel_prev_q;
  logic                  sel_changed;
  logic [CNT_W-1:0]      db_cnt_q;
  logic [CNT_W-1:0]      db_cnt_next;
  logic                  accept;
  logic                  pend_q;
  logic                  pend_next;

  logic                  page_q;
  logic                  page_next;
  logic [BCD_W-1:0]      snap_q;
  logic [BCD_W-1:0]      snap_next;

  logic [3:0]            digit_code;
  logic [NUM_DIGITS-1:0] an_onehot;
  logic [6:0]            glyph;

  assign tick        = (div_q == DIV_LAST);
  assign frame_end   = tick && (idx_q == IDX_LAST);
  assign sel_sync    = sync_q[1];
  assign sel_changed = sel_sync ^ sel_prev_q;
  assign page_active = page_q;

  always_comb begin
    idx_next = idx_q;
    if (tick) begin
      idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Count ticks while the synchronised switch differs from the pending page;
  // any edge of the synchronised level, even between ticks, restarts the count.
  always_comb begin
    accept      = 1'b0;
    db_cnt_next = db_cnt_q;
    if (sel_changed || (sel_sync == pend_q)) begin
      db_cnt_next = '0;
    end else if (tick) begin
      if (db_cnt_q == CNT_LAST) begin
        accept      = 1'b1;
        db_cnt_next = '0;
      end else begin
        db_cnt_next = db_cnt_q + 1'b1;
      end
    end
    pend_next = accept ? sel_sync : pend_q;
  end

  // pend_next already includes an acceptance on this same tick.
  always_comb begin
    page_next = page_q;
    snap_next = snap_q;
    if (frame_end) begin
      page_next = pend_next;
      snap_next = pend_next ? page1_bcd : page0_bcd;
    end
  end

  // Select from next-state index/snapshot so the registered outputs show the
  // new digit in the cycle right after the tick.
  always_comb begin
    digit_code = BLANK;
    an_onehot  = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_next == IDX_W'(k)) begin
        digit_code   = snap_next[4*k +: 4];
        an_onehot[k] = 1'b1;
      end
    end
  end

  bcd_to_seg u_dec (
    .bcd (digit_code),
    .seg (glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      idx_q      <= '0;
      sync_q     <= '0;
      sel_prev_q <= 1'b0;
      db_cnt_q   <= '0;
      pend_q     <= 1'b0;
      page_q     <= 1'b0;
      snap_q     <= {NUM_DIGITS{BLANK}};
      seg        <= SEG_XOR;
      an         <= AN_XOR;
    end else begin
      div_q      <= tick ? '0 : div_q + 1'b1;
      idx_q      <= idx_next;
      sync_q     <= {sync_q[0], page_sel};
      sel_prev_q <= sel_sync;
      db_cnt_q   <= db_cnt_next;
      pend_q     <= pend_next;
      page_q     <= page_next;
      snap_q     <= snap_next;
      if (tick) begin
        seg <= glyph ^ SEG_XOR;
        an  <= an_onehot ^ AN_XOR;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner (4 digits, 4 clk per slot, 2-tick debounce,
// active-low outputs): directed sequences, a vector table and random traffic.
module tb_seven_seg_scanner;

  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 4;
  localparam int unsigned DB  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        page_sel;
  logic [15:0] page0_bcd;
  logic [15:0] page1_bcd;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        page_active;

  int n_vec = 0;
  int n_err = 0;

  seven_seg_scanner #(
    .NUM_DIGITS     (N),
    .CLK_DIV        (DIV),
    .DEBOUNCE_TICKS (DB),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .page_sel    (page_sel),
    .page0_bcd   (page0_bcd),
    .page1_bcd   (page1_bcd),
    .seg         (seg),
    .an          (an),
    .page_active (page_active)
  );

  always #5 clk = ~clk;

  // Lit segments per code, bit 0 = a.
  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  // Reference model state: cycle/tick counts, page_sel history, snapshot.
  int unsigned m_cyc;
  int unsigned m_ticks;
  int unsigned m_stable;
  bit          m_started;
  bit          m_pend;
  bit          m_page;
  bit          m_hist [$];
  logic [3:0]  m_snap [4];

  logic [6:0]  fr_seg [4];

  typedef struct packed {
    logic            sel;
    logic [15:0]     p0;
    logic [15:0]     p1;
    logic            exp_page;
    logic [3:0][6:0] exp_seg;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit s;
    bit s_prev;
    bit tk;
    if (rst) begin
      m_cyc     = 0;
      m_ticks   = 0;
      m_stable  = 0;
      m_started = 1'b0;
      m_pend    = 1'b0;
      m_page    = 1'b0;
      m_hist    = '{1'b0, 1'b0, 1'b0};
      for (int d = 0; d < 4; d++) m_snap[d] = 4'hF;
    end else begin
      s      = m_hist[m_hist.size() - 2];
      s_prev = m_hist[m_hist.size() - 3];
      m_hist.push_back(page_sel === 1'b1);
      void'(m_hist.pop_front());
      m_cyc++;
      tk = (m_cyc % DIV == 0);
      if (s != s_prev) begin
        m_stable = 0;
      end else if (tk) begin
        m_stable++;
        if (s != m_pend && m_stable >= DB) m_pend = s;
      end
      if (tk) begin
        m_ticks++;
        m_started = 1'b1;
        if (m_ticks % N == 0) begin
          m_page = m_pend;
          for (int d = 0; d < 4; d++)
            m_snap[d] = m_page ? page1_bcd[4*d +: 4] : page0_bcd[4*d +: 4];
        end
      end
    end
  endtask

  task automatic check_model();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    int         idx;
    if (!m_started) begin
      e_an  = 4'hF;
      e_seg = 7'h7F;
    end else begin
      idx   = int'(m_ticks % N);
      e_an  = ~(4'b0001 << idx);
      e_seg = ~glyph_tab[m_snap[idx]];
    end
    check("model_an", 32'(an), 32'(e_an));
    check("model_seg", 32'(seg), 32'(e_seg));
    check("model_page", 32'(page_active), 32'(m_page));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic wait_an(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (an === target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic read_frame(output bit ok);
    bit w;
    ok = 1'b1;
    wait_an(4'b1101, w); ok &= w; fr_seg[1] = seg;
    wait_an(4'b1011, w); ok &= w; fr_seg[2] = seg;
    wait_an(4'b0111, w); ok &= w; fr_seg[3] = seg;
    wait_an(4'b1110, w); ok &= w; fr_seg[0] = seg;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit saw;
    bit rose;

    tbl[0] = '{1'b0, 16'h1234, 16'h0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
    tbl[1] = '{1'b1, 16'h1234, 16'h0A9F, 1'b1, {7'h40, 7'h3F, 7'h10, 7'h7F}};
    tbl[2] = '{1'b0, 16'h5678, 16'h0A9F, 1'b0, {7'h12, 7'h02, 7'h78, 7'h00}};
    tbl[3] = '{1'b1, 16'h5678, 16'hBCDE, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
    tbl[4] = '{1'b1, 16'h5678, 16'h4A0B, 1'b1, {7'h19, 7'h3F, 7'h40, 7'h7F}};

    // Reset release and first scan of 1234
    rst       = 1'b1;
    page_sel  = 1'b0;
    page0_bcd = 16'h1234;
    page1_bcd = 16'h0000;
    step();
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_page", 32'(page_active), 32'h0);
    step();
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      case (k)
        3:  check("rel_idle_an", 32'(an), 32'hF);
        4: begin
          check("rel_an_d1", 32'(an), 32'b1101);
          check("rel_preframe_blank", 32'(seg), 32'h7F);
        end
        8:  check("rel_an_d2", 32'(an), 32'b1011);
        12: check("rel_an_d3", 32'(an), 32'b0111);
        16: begin
          check("rel_an_d0", 32'(an), 32'b1110);
          check("rel_seg_d0", 32'(seg), 32'h19);
        end
        20: check("rel_seg_d1", 32'(seg), 32'h30);
        default: ;
      endcase
    end

    // One-tick glitch on page_sel must be rejected
    saw      = 1'b0;
    page_sel = 1'b1;
    repeat (4) begin
      step();
      saw |= (page_active === 1'b1);
    end
    page_sel = 1'b0;
    repeat (48) begin
      step();
      saw |= (page_active === 1'b1);
    end
    check("glitch_page", 32'(saw), 32'h0);

    // Mid-frame data change stays hidden until the next frame
    page0_bcd = 16'h1111;
    repeat (40) step();
    wait_an(4'b1110, ok);
    check("mid_sync", 32'(ok), 32'h1);
    step();
    step();
    page0_bcd = 16'h2222;
    read_frame(ok);
    check("mid_frame_sync", 32'(ok), 32'h1);
    check("mid_d1", 32'(fr_seg[1]), 32'h79);
    check("mid_d2", 32'(fr_seg[2]), 32'h79);
    check("mid_d3", 32'(fr_seg[3]), 32'h79);
    check("next_d0", 32'(fr_seg[0]), 32'h24);

    // Held page change lands on a frame boundary
    page1_bcd = 16'h0A9F;
    page_sel  = 1'b1;
    rose      = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (page_active === 1'b1) begin
        rose = 1'b1;
        check("page_rise_an", 32'(an), 32'b1110);
        check("page_rise_delay", 32'(i >= 8), 32'h1);
        break;
      end
    end
    check("page_rise_seen", 32'(rose), 32'h1);

    for (int v = 0; v < 5; v++) begin
      page_sel  = tbl[v].sel;
      page0_bcd = tbl[v].p0;
      page1_bcd = tbl[v].p1;
      repeat (48) step();
      check("tbl_page", 32'(page_active), 32'(tbl[v].exp_page));
      read_frame(ok);
      check("tbl_frame_sync", 32'(ok), 32'h1);
      for (int d = 0; d < 4; d++)
        check("tbl_seg", 32'(fr_seg[d]), 32'(tbl[v].exp_seg[d]));
    end

    // Reset while index 2 is displayed
    wait_an(4'b1011, ok);
    check("rst_mid_sync", 32'(ok), 32'h1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_an", 32'(an), 32'hF);
    check("rst_mid_seg", 32'(seg), 32'h7F);
    check("rst_mid_page", 32'(page_active), 32'h0);
    repeat (3) step();
    check("rst_mid_idle", 32'(an), 32'hF);
    step();
    check("rst_mid_restart", 32'(an), 32'b1101);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 29) == 0) page_sel = ~page_sel;
      if ($urandom_range(0, 59) == 0) page0_bcd = 16'($urandom);
      if ($urandom_range(0, 59) == 0) page1_bcd = 16'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
